// File: rtl/matvec_sequencer.sv
// Sequences a shared dot-product datapath over an N x N matrix-vector product, one row per cycle.
// Optional macro MATVEC_CIRCULANT_EN: read only row 0 and derive the other rows by rotation.
module matvec_sequencer #(
    parameter int WORD_WIDTH  = 31,
    parameter int VECTOR_SIZE = 16,
    parameter int ADDR_WIDTH  = $clog2(VECTOR_SIZE)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [WORD_WIDTH*VECTOR_SIZE-1:0] in_vec,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [WORD_WIDTH*VECTOR_SIZE-1:0] out_vec,
    output logic                              busy,
    output logic                              row_rd,
    output logic [ADDR_WIDTH-1:0]             row_addr,
    input  logic [WORD_WIDTH*VECTOR_SIZE-1:0] row_data,
    output logic [WORD_WIDTH*VECTOR_SIZE-1:0] dp_vec1,
    output logic [WORD_WIDTH*VECTOR_SIZE-1:0] dp_vec2,
    input  logic [WORD_WIDTH-1:0]             dp_result
);
    localparam int VW = WORD_WIDTH * VECTOR_SIZE;
    localparam logic [ADDR_WIDTH-1:0] K_LAST = ADDR_WIDTH'(VECTOR_SIZE - 1);
    localparam logic [ADDR_WIDTH-1:0] K_PRE  = ADDR_WIDTH'(VECTOR_SIZE - 2);
`ifdef MATVEC_CIRCULANT_EN
    localparam bit CIRCULANT = 1'b1;
`else
    localparam bit CIRCULANT = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t                  state_reg;
    logic [ADDR_WIDTH-1:0]   k_reg;
    logic [VW-1:0]           state_vec_reg;
    logic [VW-1:0]           out_vec_reg;
    logic                    in_ready_reg;
    logic                    out_valid_reg;
    logic                    busy_reg;
    logic                    row_rd_reg;
    logic [ADDR_WIDTH-1:0]   row_addr_reg;
    logic [VW-1:0]           row_vec;
    logic                    in_run;

    assign in_run = (state_reg == RUN);

`ifdef MATVEC_CIRCULANT_EN
    logic [VW-1:0] rot_reg;
    logic [VW-1:0] rot_src;
    logic [VW-1:0] rot_next;

    // Row 0 arrives from memory in the first RUN cycle; later rows come from the rotated copy.
    assign rot_src = (k_reg == '0) ? row_data : rot_reg;

    generate
        for (genvar gi = 0; gi < VECTOR_SIZE; gi++) begin : g_rot
            assign rot_next[gi*WORD_WIDTH +: WORD_WIDTH] =
                rot_src[((gi + VECTOR_SIZE - 1) % VECTOR_SIZE)*WORD_WIDTH +: WORD_WIDTH];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset) begin
            rot_reg <= '0;
        end else if (in_run) begin
            rot_reg <= rot_next;
        end
    end

    assign row_vec = rot_src;
`else
    assign row_vec = row_data;
`endif

    assign dp_vec1   = in_run ? row_vec : '0;
    assign dp_vec2   = in_run ? state_vec_reg : '0;
    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign out_vec   = out_vec_reg;
    assign busy      = busy_reg;
    assign row_rd    = row_rd_reg;
    assign row_addr  = row_addr_reg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg     <= IDLE;
            k_reg         <= '0;
            state_vec_reg <= '0;
            out_vec_reg   <= '0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            row_rd_reg    <= 1'b0;
            row_addr_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        state_reg     <= LOAD;
                        state_vec_reg <= in_vec;
                        in_ready_reg  <= 1'b0;
                        busy_reg      <= 1'b1;
                        row_rd_reg    <= 1'b1;
                        row_addr_reg  <= '0;
                    end
                end
                LOAD: begin
                    // Outputs are registered, so the read shown in RUN k is scheduled one cycle early.
                    state_reg    <= RUN;
                    k_reg        <= '0;
                    row_rd_reg   <= !CIRCULANT;
                    row_addr_reg <= CIRCULANT ? '0 : ADDR_WIDTH'(1);
                end
                RUN: begin
                    out_vec_reg[k_reg*WORD_WIDTH +: WORD_WIDTH] <= dp_result;
                    if (k_reg == K_LAST) begin
                        state_reg     <= DONE;
                        k_reg         <= '0;
                        out_valid_reg <= 1'b1;
                        row_rd_reg    <= 1'b0;
                        row_addr_reg  <= '0;
                    end else begin
                        k_reg <= k_reg + ADDR_WIDTH'(1);
                        if (!CIRCULANT && (k_reg != K_PRE)) begin
                            row_rd_reg   <= 1'b1;
                            row_addr_reg <= k_reg + ADDR_WIDTH'(2);
                        end else begin
                            row_rd_reg   <= 1'b0;
                            row_addr_reg <= '0;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_reg     <= IDLE;
                        out_valid_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                        in_ready_reg  <= 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_matvec_sequencer.sv
// Directed bench for matvec_sequencer with a behavioural row memory and M31 dot-product model.
// Build with MATVEC_CIRCULANT_EN defined to exercise the circulant variant.
module tb_matvec_sequencer;
    localparam int W  = 31;
    localparam int N  = 16;
    localparam int AW = 4;
    localparam int VW = W * N;
    localparam longint P = 64'd2147483647;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [VW-1:0] in_vec = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [VW-1:0] out_vec;
    logic          busy;
    logic          row_rd;
    logic [AW-1:0] row_addr;
    logic [VW-1:0] row_data = '0;
    logic [VW-1:0] dp_vec1;
    logic [VW-1:0] dp_vec2;
    logic [W-1:0]  dp_result;

    logic [VW-1:0] mem [N];
    int rd_count [N];
    int checks = 0;
    int errors = 0;

    matvec_sequencer #(.WORD_WIDTH(W), .VECTOR_SIZE(N), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
        .out_valid(out_valid), .out_ready(out_ready), .out_vec(out_vec), .busy(busy),
        .row_rd(row_rd), .row_addr(row_addr), .row_data(row_data),
        .dp_vec1(dp_vec1), .dp_vec2(dp_vec2), .dp_result(dp_result)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (row_rd) begin
            row_data <= mem[row_addr];
            rd_count[row_addr] = rd_count[row_addr] + 1;
        end
    end

    always_comb begin
        longint acc;
        acc = 0;
        for (int j = 0; j < N; j++)
            acc = (acc + (longint'(dp_vec1[j*W +: W]) * longint'(dp_vec2[j*W +: W])) % P) % P;
        dp_result = acc[W-1:0];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [VW-1:0] ramp_vec(input bit reversed);
        logic [VW-1:0] v;
        v = '0;
        for (int j = 0; j < N; j++)
            v[j*W +: W] = reversed ? W'(N - j) : W'(j + 1);
        return v;
    endfunction

    task automatic load_identity();
        for (int r = 0; r < N; r++) begin
            mem[r] = '0;
            mem[r][r*W +: W] = W'(1);
        end
    endtask

    task automatic load_ones();
        for (int r = 0; r < N; r++)
            for (int j = 0; j < N; j++)
                mem[r][j*W +: W] = W'(1);
    endtask

    task automatic clear_counts();
        for (int r = 0; r < N; r++) rd_count[r] = 0;
    endtask

    // Present one vector and return the cycle offset of out_valid relative to the handshake cycle.
    task automatic send_vec(input logic [VW-1:0] v, output int lat);
        in_vec   = v;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: in_ready=%b out_valid=%b busy=%b required 1 0 0", in_ready, out_valid, busy);
        end
        checks++;
        if (row_rd !== 1'b0 || row_addr !== '0) begin
            errors++;
            $display("FAIL reset_row: row_rd=%b row_addr=%0d required 0 0", row_rd, row_addr);
        end
        checks++;
        if (out_vec !== '0 || dp_vec1 !== '0 || dp_vec2 !== '0) begin
            errors++;
            $display("FAIL reset_vec: out_vec/dp_vec not all zero");
        end
        $display("test_reset: done");
    endtask

    task automatic test_identity();
        int lat;
        logic [VW-1:0] exp_v;
        load_identity();
        clear_counts();
        exp_v = ramp_vec(1'b0);
        send_vec(exp_v, lat);
        checks++;
        if (lat !== 18) begin
            errors++;
            $display("FAIL identity_latency: got %0d required 18", lat);
        end
        checks++;
        if (out_vec !== exp_v) begin
            errors++;
            $display("FAIL identity_out: got %h required %h", out_vec, exp_v);
        end
        for (int r = 0; r < N; r++) begin
            int exp_cnt;
`ifdef MATVEC_CIRCULANT_EN
            exp_cnt = (r == 0) ? 1 : 0;
`else
            exp_cnt = 1;
`endif
            checks++;
            if (rd_count[r] !== exp_cnt) begin
                errors++;
                $display("FAIL identity_reads[%0d]: got %0d required %0d", r, rd_count[r], exp_cnt);
            end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL identity_release: in_ready=%b out_valid=%b busy=%b required 1 0 0", in_ready, out_valid, busy);
        end
        checks++;
        if (out_vec !== exp_v) begin
            errors++;
            $display("FAIL identity_hold_after_done: got %h required %h", out_vec, exp_v);
        end
        $display("test_identity: latency %0d", lat);
    endtask

    task automatic test_ones();
        int lat;
        load_ones();
        send_vec(ramp_vec(1'b0), lat);
        for (int k = 0; k < N; k++) begin
            checks++;
            if (out_vec[k*W +: W] !== W'(136)) begin
                errors++;
                $display("FAIL ones_out[%0d]: got %0d required 136", k, out_vec[k*W +: W]);
            end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        $display("test_ones: latency %0d", lat);
    endtask

`ifdef MATVEC_CIRCULANT_EN
    task automatic test_circulant();
        int lat;
        int total;
        logic [W-1:0] exp_e;
        for (int r = 0; r < N; r++) mem[r] = '0;
        mem[0][0*W +: W] = W'(1);
        mem[0][1*W +: W] = W'(2);
        clear_counts();
        send_vec(ramp_vec(1'b0), lat);
        checks++;
        if (lat !== 18) begin
            errors++;
            $display("FAIL circ_latency: got %0d required 18", lat);
        end
        for (int k = 0; k < N; k++) begin
            exp_e = (k == N - 1) ? W'(18) : W'(3 * k + 5);
            checks++;
            if (out_vec[k*W +: W] !== exp_e) begin
                errors++;
                $display("FAIL circ_out[%0d]: got %0d required %0d", k, out_vec[k*W +: W], exp_e);
            end
        end
        total = 0;
        for (int r = 0; r < N; r++) total += rd_count[r];
        checks++;
        if (rd_count[0] !== 1 || total !== 1) begin
            errors++;
            $display("FAIL circ_reads: row0=%0d total=%0d required 1 1", rd_count[0], total);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        $display("test_circulant: latency %0d", lat);
    endtask
`endif

    task automatic test_backpressure();
        int lat;
        logic [VW-1:0] exp_v;
        load_identity();
        exp_v = ramp_vec(1'b1);
        send_vec(exp_v, lat);
        for (int c = 0; c < 5; c++) begin
            in_valid = c[0];
            in_vec   = '1;
            checks++;
            if (out_valid !== 1'b1 || out_vec !== exp_v || in_ready !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold[%0d]: out_valid=%b in_ready=%b busy=%b vec_ok=%b required 1 0 1 1",
                         c, out_valid, in_ready, busy, out_vec === exp_v);
            end
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: in_ready=%b out_valid=%b busy=%b required 1 0 0", in_ready, out_valid, busy);
        end
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_no_accept: busy=%b required 0", busy);
        end
        $display("test_backpressure: done");
    endtask

    task automatic test_reset_mid_run();
        int lat;
        logic [VW-1:0] exp_v;
        load_identity();
        exp_v = ramp_vec(1'b0);
        in_vec   = exp_v;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int c = 0; c < 8; c++) tick();
        reset = 1'b0;
        tick();
        checks++;
        if (out_vec !== '0 || out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrun_reset: out_valid=%b busy=%b in_ready=%b vec_zero=%b required 0 0 1 1",
                     out_valid, busy, in_ready, out_vec === '0);
        end
        reset = 1'b1;
        tick();
        send_vec(exp_v, lat);
        checks++;
        if (lat !== 18 || out_vec !== exp_v) begin
            errors++;
            $display("FAIL midrun_recover: latency %0d required 18, vec_ok=%b", lat, out_vec === exp_v);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        $display("test_reset_mid_run: recovery latency %0d", lat);
    endtask

    task automatic test_back_to_back();
        int cyc;
        int accepts;
        int nvalid;
        int t_valid [2];
        logic [VW-1:0] exp_v [2];
        logic hs;
        load_identity();
        exp_v[0] = ramp_vec(1'b0);
        exp_v[1] = ramp_vec(1'b1);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_vec    = exp_v[0];
        cyc = 0;
        accepts = 0;
        nvalid = 0;
        t_valid[0] = 0;
        t_valid[1] = 0;
        while (nvalid < 2 && cyc < 200) begin
            hs = in_valid && in_ready;
            tick();
            cyc++;
            if (hs) begin
                accepts++;
                if (accepts == 1) in_vec = exp_v[1];
                else in_valid = 1'b0;
            end
            if (out_valid === 1'b1) begin
                t_valid[nvalid] = cyc;
                checks++;
                if (out_vec !== exp_v[nvalid]) begin
                    errors++;
                    $display("FAIL b2b_out[%0d]: got %h required %h", nvalid, out_vec, exp_v[nvalid]);
                end
                nvalid++;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (nvalid !== 2 || (t_valid[1] - t_valid[0]) !== 19) begin
            errors++;
            $display("FAIL b2b_interval: got %0d results, spacing %0d required 2 results, spacing 19",
                     nvalid, t_valid[1] - t_valid[0]);
        end
        tick();
        $display("test_back_to_back: spacing %0d", t_valid[1] - t_valid[0]);
    endtask

    initial begin
        for (int r = 0; r < N; r++) mem[r] = '0;
        clear_counts();
        test_reset();
        test_identity();
        test_ones();
`ifdef MATVEC_CIRCULANT_EN
        test_circulant();
`endif
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/matvec_sequencer.md
# matvec_sequencer

Sequences one shared `vector_dot_product` datapath to compute an N×N matrix–vector product over M31, such as the Monolith MDS layer. It accepts a state vector and reads one coefficient row per cycle from an external synchronous row memory. It drives the row and the state into the dot-product unit and collects one output word per cycle into a result vector, which is returned over a valid/ready handshake.

## Interface
Parameters:
- `WORD_WIDTH`, 31, field element width.
- `VECTOR_SIZE`, 16, vector length N and matrix dimension.
- `ADDR_WIDTH`, `$clog2(VECTOR_SIZE)`, row address width.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  input vector valid.
- `in_ready`  out  1  block can accept an input vector.
- `in_vec`  in  `WORD_WIDTH` × N  input state vector.
- `out_valid`  out  1  result vector valid.
- `out_ready`  in  1  consumer accepts the result.
- `out_vec`  out  `WORD_WIDTH` × N  result vector.
- `busy`  out  1  high in every state except IDLE.
- `row_rd`  out  1  row memory read strobe.
- `row_addr`  out  `ADDR_WIDTH`  row memory address.
- `row_data`  in  `WORD_WIDTH` × N  row memory data; valid the cycle after the `row_rd` request.
- `dp_vec1`  out  `WORD_WIDTH` × N  coefficient row to the dot-product unit.
- `dp_vec2`  out  `WORD_WIDTH` × N  state vector to the dot-product unit.
- `dp_result`  in  `WORD_WIDTH`  combinational dot-product result, same cycle.

## Operation
- FSM states: IDLE, LOAD, RUN, DONE. A row counter `k` (`ADDR_WIDTH` bits) is used in RUN.
- IDLE:
  - `in_ready`=1.
  - On `in_valid && in_ready`, register `in_vec` into the state register and go to LOAD.
- LOAD: one cycle.
  - `row_rd`=1, `row_addr`=0.
  - Set k=0 and go to RUN.
- RUN: k = 0..N-1.
  - `row_data` holds row k. Drive `dp_vec1` from the row source and `dp_vec2` from the state register.
  - Capture `dp_result` into `out_vec[k]` at the end of the cycle.
  - If k<N-1, assert `row_rd`=1 with `row_addr`=k+1 and increment k.
  - At k=N-1, go to DONE. No read is issued.
- DONE:
  - `out_valid`=1 and `out_vec` is held stable.
  - On `out_ready`, go to IDLE.
- `in_valid` is ignored while not in IDLE; `in_ready`=0 in those states.
- `dp_vec1` and `dp_vec2` are driven all-zero outside RUN.
- `row_rd`=0 and `row_addr`=0 whenever no read is issued.
- `out_vec` is copied bit-exact from `dp_result`; the canonical M31 form is the datapath's responsibility.
- `out_vec` keeps its last value after leaving DONE, until it is overwritten in the next RUN.

## Timing
- Input handshake in cycle T. LOAD is T+1. RUN is T+2..T+N+1. `out_valid` rises at T+N+2, which is T+18 for N=16.
- `out_valid` holds until the cycle in which `out_ready`=1. `in_ready` is high in the next cycle.
- Minimum issue interval is N+3 cycles. This requires `out_ready` to be held high and `in_valid` to be asserted back-to-back.
- If `out_ready` is already high when DONE is entered, DONE lasts exactly one cycle.
- Reset (`reset`=0 at a clock edge) in any state, including mid-RUN:
  - FSM goes to IDLE and k=0.
  - `out_vec`, the state register and the rotation register go to 0.
  - `out_valid`=0, `busy`=0, `row_rd`=0, `row_addr`=0 and `in_ready`=1 in the cycle after reset deasserts.
  - No partial result is ever presented.

## Configuration
- `MATVEC_CIRCULANT_EN` defined: the matrix is treated as circulant.
  - Only row 0 is read, in LOAD.
  - In RUN k=0, `dp_vec1`=`row_data`, which is also latched into a rotation register.
  - For k>0, `dp_vec1[j]` = c[(j−k) mod N], where c is row 0. The rotation register is rotated right by one element each RUN cycle.
  - `row_rd`=0 in all RUN cycles.
  - Latency is identical to the non-circulant build.
- `MATVEC_CIRCULANT_EN` undefined: the rotation register does not exist. Row k is read from address k, as described in Operation.

## Test plan
- Identity matrix, `in_vec`=1..16 → `out_vec`=1..16 with `out_valid` at T+18. Row addresses 0..15 are each read exactly once.
- All-ones matrix, `in_vec`=1..16 → every `out_vec` element is 136.
- `MATVEC_CIRCULANT_EN` build, row 0 = {1,2,0,…,0} (c[0]=1, c[1]=2), `in_vec`=1..16 → `out_vec[k]` = in[k]+2·in[(k+1) mod 16]; `out_vec[0]`=5, `out_vec[15]`=18. `row_rd` is high only in LOAD.
- Backpressure: `out_ready`=0 for 5 cycles in DONE → `out_valid` and `out_vec` stay stable. `in_valid` pulses in that window are not accepted. The block returns to IDLE the cycle after `out_ready`=1.
- `reset` asserted at RUN k=7 → the next cycle shows IDLE, `out_vec` all 0, `out_valid`=0. A new vector then completes normally.
- Back-to-back: two vectors with `out_ready` held high → second `out_valid` arrives 19 cycles after the first.
